// File: rtl/clk_div_bank_pkg.sv
// Shared clock-divider configuration: divider constants and per-channel reset divisors.
package clk_div_bank_pkg;

  localparam int unsigned clk_divider_pll = 0;
  localparam int unsigned clk_divider_rtc = 1524;
  localparam int unsigned clks_per_bit    = 433;

  localparam int unsigned MAX_CHANNELS = 8;

  typedef logic [MAX_CHANNELS-1:0][31:0] clk_div_init_t;

  // ch0 in the low word; unused channels reset to zero
  localparam clk_div_init_t DIV_INIT_DEFAULT = {
    32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
    32'(clks_per_bit),
    32'(clk_divider_rtc),
    32'(clk_divider_pll)
  };

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow divisor, tick and optional toggle.
// Optional toggle output enabled by defining CLK_DIV_TOGGLE_EN.
module clk_div_chan
  import clk_div_bank_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter logic [WIDTH-1:0] INIT = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             wen,
  input  logic [WIDTH-1:0] wdata,
  output logic             tick,
  output logic             toggle,
  output logic [WIDTH-1:0] active
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] act;
  logic [WIDTH-1:0] shd;
  logic             pend;
  logic             term;

  assign term   = (cnt == act);
  assign active = act;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
      act  <= INIT;
      shd  <= INIT;
      pend <= 1'b0;
    end else if (!enable) begin
      cnt  <= '0;
      tick <= 1'b0;
      pend <= 1'b0;
      if (wen) begin
        act <= wdata;
        shd <= wdata;
      end else if (pend) begin
        act <= shd;
      end
    end else if (term) begin
      // a write landing on this edge waits for the next terminal count
      cnt  <= '0;
      tick <= 1'b1;
      if (pend) act <= shd;
      if (wen) shd <= wdata;
      pend <= wen;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
      if (wen) begin
        shd  <= wdata;
        pend <= 1'b1;
      end
    end
  end

`ifdef CLK_DIV_TOGGLE_EN
  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      toggle <= 1'b0;
    end else if (term) begin
      toggle <= ~toggle;
    end
  end
`else
  assign toggle = 1'b0;
`endif

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent programmable clock-enable dividers.
// Optional toggle output enabled by defining CLK_DIV_TOGGLE_EN.
module clk_div_bank
  import clk_div_bank_pkg::*;
#(
  parameter int unsigned   CHANNELS = 3,
  parameter int unsigned   WIDTH    = 16,
  parameter clk_div_init_t DIV_INIT = DIV_INIT_DEFAULT
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       div_wen,
  input  logic [WIDTH-1:0]          div_wdata,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS-1:0]       toggle,
  output logic [CHANNELS*WIDTH-1:0] div_active
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    clk_div_chan #(
      .WIDTH(WIDTH),
      .INIT (DIV_INIT[i][WIDTH-1:0])
    ) u_chan (
      .clock (clock),
      .reset (reset),
      .enable(enable[i]),
      .wen   (div_wen[i]),
      .wdata (div_wdata),
      .tick  (tick[i]),
      .toggle(toggle[i]),
      .active(div_active[i*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: vector table, directed period
// sequences and randomized traffic against a period-level reference model.
module tb_clk_div_bank;

  localparam int N = 3;
  localparam int W = 16;
  localparam int INIT [N] = '{0, 1524, 433};

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   en;
  logic [N-1:0]   wen;
  logic [W-1:0]   wdata;
  logic [N-1:0]   tick;
  logic [N-1:0]   toggle;
  logic [N*W-1:0] div_active;

  int tests = 0;
  int fails = 0;
  int edge_no = 0;
  int base;

  int m_phase [N];
  int m_len   [N];
  int m_nxt   [N];
  bit m_tick  [N];
  bit m_tog   [N];

  int tq [N][$];

  typedef struct {
    logic       rst;
    logic [2:0] en;
    logic [2:0] wen;
    logic [W-1:0] wd;
    logic [2:0] t;
    logic [W-1:0] a0;
  } vec_t;

  vec_t vt [13];

  always #5 clk = ~clk;

  clk_div_bank dut (
    .clock     (clk),
    .reset     (rst),
    .enable    (en),
    .div_wen   (wen),
    .div_wdata (wdata),
    .tick      (tick),
    .toggle    (toggle),
    .div_active(div_active)
  );

  task automatic chk(input string name, input int ch, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s ch%0d edge %0d: got %0d want %0d", name, ch, edge_no, got, want);
    end
  endtask

  // reference: a period is len+1 edges; a new length queued while running
  // takes over when the current period ends
  task automatic model_edge();
    for (int c = 0; c < N; c++) begin
      if (rst) begin
        m_phase[c] = 0; m_len[c] = INIT[c]; m_nxt[c] = -1;
        m_tick[c] = 0;  m_tog[c] = 0;
      end else if (!en[c]) begin
        if (wen[c]) m_len[c] = int'(wdata);
        else if (m_nxt[c] >= 0) m_len[c] = m_nxt[c];
        m_nxt[c] = -1; m_phase[c] = 0;
        m_tick[c] = 0; m_tog[c] = 0;
      end else if (m_phase[c] == m_len[c]) begin
        m_tick[c] = 1; m_tog[c] = !m_tog[c]; m_phase[c] = 0;
        if (m_nxt[c] >= 0) m_len[c] = m_nxt[c];
        m_nxt[c] = wen[c] ? int'(wdata) : -1;
      end else begin
        m_phase[c]++; m_tick[c] = 0;
        if (wen[c]) m_nxt[c] = int'(wdata);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    edge_no++;
    for (int c = 0; c < N; c++) begin
      chk("tick", c, int'(tick[c]), int'(m_tick[c]));
      chk("active", c, int'(div_active[c*W +: W]), m_len[c]);
`ifdef CLK_DIV_TOGGLE_EN
      chk("toggle", c, int'(toggle[c]), int'(m_tog[c]));
`else
      chk("toggle", c, int'(toggle[c]), 0);
`endif
      if (tick[c]) tq[c].push_back(edge_no);
    end
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1; en = '0; wen = '0; wdata = '0;
    step();
    rst = 1'b0;
    for (int c = 0; c < N; c++) tq[c].delete();
    base = edge_no;
  endtask

  function automatic int qat(input int ch, input int i);
    if (tq[ch].size() > i) return tq[ch][i] - base;
    return -1;
  endfunction

  initial begin
    rst = 1'b1; en = '0; wen = '0; wdata = '0;
    for (int c = 0; c < N; c++) begin
      m_phase[c] = 0; m_len[c] = INIT[c]; m_nxt[c] = -1;
      m_tick[c] = 0;  m_tog[c] = 0;
    end

    vt[0]  = '{1'b1, 3'b000, 3'b000, 16'd0, 3'b000, 16'd0};
    vt[1]  = '{1'b0, 3'b000, 3'b001, 16'd1, 3'b000, 16'd1};
    vt[2]  = '{1'b0, 3'b001, 3'b000, 16'd0, 3'b000, 16'd1};
    vt[3]  = '{1'b0, 3'b001, 3'b000, 16'd0, 3'b001, 16'd1};
    vt[4]  = '{1'b0, 3'b001, 3'b000, 16'd0, 3'b000, 16'd1};
    vt[5]  = '{1'b0, 3'b001, 3'b000, 16'd0, 3'b001, 16'd1};
    vt[6]  = '{1'b0, 3'b001, 3'b001, 16'd0, 3'b000, 16'd1};
    vt[7]  = '{1'b0, 3'b001, 3'b000, 16'd0, 3'b001, 16'd0};
    vt[8]  = '{1'b0, 3'b001, 3'b000, 16'd0, 3'b001, 16'd0};
    vt[9]  = '{1'b0, 3'b000, 3'b000, 16'd0, 3'b000, 16'd0};
    vt[10] = '{1'b1, 3'b111, 3'b111, 16'd7, 3'b000, 16'd0};
    vt[11] = '{1'b1, 3'b111, 3'b000, 16'd7, 3'b000, 16'd0};
    vt[12] = '{1'b0, 3'b000, 3'b000, 16'd0, 3'b000, 16'd0};

    for (int r = 0; r < 13; r++) begin
      rst = vt[r].rst; en = vt[r].en; wen = vt[r].wen; wdata = vt[r].wd;
      step();
      chk("vec_tick", r, int'(tick), int'(vt[r].t));
      chk("vec_act0", r, int'(div_active[W-1:0]), int'(vt[r].a0));
    end
    chk("rst_act1", 1, int'(div_active[W +: W]), 1524);
    chk("rst_act2", 2, int'(div_active[2*W +: W]), 433);

    // defaults, all enabled
    do_reset();
    en = 3'b111;
    steps(3060);
    chk("ch0_every", 0, tq[0].size(), 3060);
    chk("ch1_first", 1, qat(1, 0), 1525);
    chk("ch1_second", 1, qat(1, 1), 3050);
    chk("ch2_first", 2, qat(2, 0), 434);
    chk("ch2_second", 2, qat(2, 1), 868);

    // write mid-period on ch2
    do_reset();
    en = 3'b100;
    steps(100);
    wen = 3'b100; wdata = 16'd9;
    step();
    wen = '0;
    steps(360);
    chk("mid_first", 2, qat(2, 0), 434);
    chk("mid_second", 2, qat(2, 1), 444);
    chk("mid_third", 2, qat(2, 2), 454);

    // write on the terminal-count edge of ch1
    do_reset();
    en = 3'b010;
    steps(1524);
    wen = 3'b010; wdata = 16'd5;
    step();
    wen = '0;
    steps(1540);
    chk("tc_first", 1, qat(1, 0), 1525);
    chk("tc_second", 1, qat(1, 1), 3050);
    chk("tc_third", 1, qat(1, 2), 3056);
    chk("tc_fourth", 1, qat(1, 3), 3062);

    // disable mid-period then re-enable
    do_reset();
    en = 3'b100;
    steps(200);
    en = 3'b000;
    step();
    chk("dis_tick", 2, int'(tick[2]), 0);
    chk("dis_toggle", 2, int'(toggle[2]), 0);
    chk("dis_ticks", 2, tq[2].size(), 0);
    en = 3'b100;
    tq[2].delete();
    base = edge_no;
    steps(440);
    chk("reen_first", 2, qat(2, 0), 434);

    // randomized traffic
    do_reset();
    en = 3'b111;
    for (int k = 0; k < 4000; k++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 59) == 0) en[c] = ~en[c];
        wen[c] = ($urandom_range(0, 24) == 0);
      end
      wdata = W'($urandom_range(0, 12));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
